// File: rtl/grid_renderer.sv
// grid_renderer: Game-of-Life cell grid pixel generator with frame snapshot and 2-stage output pipeline
// Ports: clk/rst (async active-high), blank/hcount/vcount/hs_in/vs_in from the VGA timing generator,
//        grid_pack cell bits (row*GRID_W+col), pixel RRRGGGBB, hs_out/vs_out aligned to pixel,
//        frame_tick pulses when the grid snapshot is taken.
// Optional: define GRID_CURSOR_EN to add cursor_col/cursor_row and a green cursor-cell outline.
module grid_renderer #(
  parameter int GRID_W = 32,
  parameter int GRID_H = 32,
  parameter int CELL_PX = 15,
  parameter int X_OFF = 80,
  parameter int Y_OFF = 0,
  parameter logic [7:0] ALIVE_COL = 8'hFF,
  parameter logic [7:0] DEAD_COL = 8'h00,
  parameter logic [7:0] BORDER_COL = 8'hE0
) (
  input  logic clk,
  input  logic rst,
  input  logic blank,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic hs_in,
  input  logic vs_in,
  input  logic [GRID_W*GRID_H-1:0] grid_pack,
`ifdef GRID_CURSOR_EN
  input  logic [$clog2(GRID_W)-1:0] cursor_col,
  input  logic [$clog2(GRID_H)-1:0] cursor_row,
`endif
  output logic [7:0] pixel,
  output logic hs_out,
  output logic vs_out,
  output logic frame_tick
);
  localparam int N = GRID_W*GRID_H;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(GRID_W);
  localparam int RW = $clog2(GRID_H);
  localparam int SW = $clog2(CELL_PX);
  localparam logic [10:0] XL = 11'(X_OFF);
  localparam logic [10:0] XR = 11'(X_OFF + GRID_W*CELL_PX + 1);
  localparam logic [10:0] YT = 11'(Y_OFF);
  localparam logic [10:0] GWP = 11'(GRID_W*CELL_PX);
  localparam logic [10:0] GHP = 11'(GRID_H*CELL_PX);
  localparam logic [SW-1:0] SMAX = SW'(CELL_PX-1);
  localparam logic [CW-1:0] CMAX = CW'(GRID_W-1);
  localparam logic [IW-1:0] GW = IW'(GRID_W);
  logic [N-1:0] snap_q;
  logic [10:0] vcount_q, vy, hx;
  logic [SW-1:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [IW-1:0] row_base_q, row_base_d, idx_d, idx1_q;
  logic line_chg, snap_take, vert_in, h_run, in_grid, at_border, x_wrap, y_wrap, y_clr, y_step, cur_d;
  logic frame_q, blank1_q, border1_q, grid1_q, cur1_q, hs1_q, vs1_q, hs_q, vs_q;
  logic [7:0] pixel_q;
  // Range checks use wrapping subtraction so an offset of 0 needs no special case.
  always_comb begin
    line_chg = vcount != vcount_q;
    snap_take = line_chg && vcount == 11'd0;
    vy = vcount - YT;
    hx = hcount - XL - 11'd1;
    vert_in = vy < GHP;
    h_run = hx < GWP;
    in_grid = vert_in && h_run;
    at_border = vert_in && (hcount == XL || hcount == XR);
    x_wrap = sub_x_q == SMAX;
    y_wrap = sub_y_q == SMAX;
    y_clr = line_chg && vcount == YT;
    y_step = line_chg && vert_in && !y_clr;
    sub_x_d = hcount == XL ? '0 : h_run ? (x_wrap ? '0 : sub_x_q + 1'b1) : sub_x_q;
    // col saturates on the last cell so it can never address past the row
    col_d = hcount == XL ? '0 : (h_run && x_wrap && col_q != CMAX) ? col_q + 1'b1 : col_q;
    sub_y_d = y_clr ? '0 : y_step ? (y_wrap ? '0 : sub_y_q + 1'b1) : sub_y_q;
    row_d = y_clr ? '0 : (y_step && y_wrap) ? row_q + 1'b1 : row_q;
    row_base_d = y_clr ? '0 : (y_step && y_wrap) ? row_base_q + GW : row_base_q;
    // vertical state is taken post-update so the first pixel of a line already sees its row
    idx_d = in_grid ? row_base_d + IW'(col_q) : '0;
  end
`ifdef GRID_CURSOR_EN
  logic [CW-1:0] cur_col_q;
  logic [RW-1:0] cur_row_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_col_q <= '0;
      cur_row_q <= '0;
    end else if (snap_take) begin
      cur_col_q <= cursor_col;
      cur_row_q <= cursor_row;
    end
  end
  assign cur_d = in_grid && col_q == cur_col_q && row_d == cur_row_q &&
                 (sub_x_q == '0 || sub_x_q == SMAX || sub_y_d == '0 || sub_y_d == SMAX);
`else
  assign cur_d = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q <= '0;
      vcount_q <= '0;
      frame_q <= 1'b0;
      sub_x_q <= '0;
      col_q <= '0;
      sub_y_q <= '0;
      row_q <= '0;
      row_base_q <= '0;
      blank1_q <= 1'b1;
      border1_q <= 1'b0;
      grid1_q <= 1'b0;
      cur1_q <= 1'b0;
      idx1_q <= '0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      pixel_q <= 8'h00;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      vcount_q <= vcount;
      if (snap_take) snap_q <= grid_pack;
      frame_q <= snap_take;
      sub_x_q <= sub_x_d;
      col_q <= col_d;
      sub_y_q <= sub_y_d;
      row_q <= row_d;
      row_base_q <= row_base_d;
      blank1_q <= blank;
      border1_q <= at_border;
      grid1_q <= in_grid;
      cur1_q <= cur_d;
      idx1_q <= idx_d;
      hs1_q <= hs_in;
      vs1_q <= vs_in;
      pixel_q <= blank1_q ? 8'h00 : border1_q ? BORDER_COL : !grid1_q ? 8'h00 :
                 cur1_q ? 8'h1C : snap_q[idx1_q] ? ALIVE_COL : DEAD_COL;
      hs_q <= hs1_q;
      vs_q <= vs1_q;
    end
  end
  assign pixel = pixel_q;
  assign hs_out = hs_q;
  assign vs_out = vs_q;
  assign frame_tick = frame_q;
endmodule

// File: tb/tb_grid_renderer.sv
// tb_grid_renderer: default 32x32 grid and a small 8x4 grid driven by one compressed VGA scan
module tb_grid_renderer;
  logic clk = 1'b0, rst, blank, hs_in, vs_in;
  logic [10:0] hcount, vcount;
  logic [1023:0] gp0;
  logic [31:0] gp1;
  logic [7:0] pix0, pix1;
  logic hs0, vs0, ft0, hs1, vs1, ft1;
  int mc0c = 0, mc0r = 0, mc1c = 0, mc1r = 0;
`ifdef GRID_CURSOR_EN
  logic [4:0] cc0, cr0;
  logic [2:0] cc1;
  logic [1:0] cr1;
  localparam bit CUR = 1'b1;
`else
  localparam bit CUR = 1'b0;
`endif
  int checks = 0, fails = 0, ticks = 0, pv = 0;
  bit force_sync = 0;
  logic [1023:0] s0;
  logic [31:0] s1;

  typedef struct { bit valid; bit dir; int h; int v; logic [7:0] p0; logic [7:0] p1; logic hs; logic vs; } rec_t;
  typedef struct { bit d; int h; int v; logic [7:0] e; } vec_t;
  rec_t prev;
  vec_t tbl[26];
  int fl[19] = '{0, 1, 14, 15, 19, 20, 21, 23, 24, 28, 32, 35, 36, 45, 59, 464, 465, 479, 480};

  grid_renderer d0 (
    .clk(clk), .rst(rst), .blank(blank), .hcount(hcount), .vcount(vcount),
    .hs_in(hs_in), .vs_in(vs_in), .grid_pack(gp0),
`ifdef GRID_CURSOR_EN
    .cursor_col(cc0), .cursor_row(cr0),
`endif
    .pixel(pix0), .hs_out(hs0), .vs_out(vs0), .frame_tick(ft0));

  grid_renderer #(.GRID_W(8), .GRID_H(4), .CELL_PX(4), .X_OFF(10), .Y_OFF(20)) d1 (
    .clk(clk), .rst(rst), .blank(blank), .hcount(hcount), .vcount(vcount),
    .hs_in(hs_in), .vs_in(vs_in), .grid_pack(gp1),
`ifdef GRID_CURSOR_EN
    .cursor_col(cc1), .cursor_row(cr1),
`endif
    .pixel(pix1), .hs_out(hs1), .vs_out(vs1), .frame_tick(ft1));

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_pix(int h, int v, bit b, logic [1023:0] s, int gw, int gh, int cp,
                                         int xo, int yo, int cc, int cr);
    int xr = xo + gw*cp + 1;
    int yb = yo + gh*cp;
    int c, r, px, py;
    if (b || v < yo || v >= yb) return 8'h00;
    if (h == xo || h == xr) return 8'hE0;
    if (h < xo || h > xr) return 8'h00;
    px = (h - xo - 1) % cp;
    py = (v - yo) % cp;
    c = (h - xo - 1) / cp;
    r = (v - yo) / cp;
    if (CUR && c == cc && r == cr && (px == 0 || px == cp-1 || py == 0 || py == cp-1)) return 8'h1C;
    return s[r*gw + c] ? 8'hFF : 8'h00;
  endfunction

  task automatic chk(string name, int h, int v, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s h=%0d v=%0d got %h expected %h at %0t", name, h, v, act, exp, $time);
    end
  endtask

  task automatic step(int h, int v, bit b, bit dir);
    rec_t cur;
    bit tk;
    hcount = 11'(h);
    vcount = 11'(v);
    blank = b;
    hs_in = force_sync ? 1'b1 : 1'($urandom);
    vs_in = force_sync ? 1'b1 : 1'($urandom);
    tk = (v == 0 && pv != 0);
    if (tk) begin
      s0 = gp0;
      s1 = gp1;
`ifdef GRID_CURSOR_EN
      mc0c = int'(cc0); mc0r = int'(cr0); mc1c = int'(cc1); mc1r = int'(cr1);
`endif
    end
    pv = v;
    cur.valid = 1;
    cur.dir = dir;
    cur.h = h;
    cur.v = v;
    cur.hs = hs_in;
    cur.vs = vs_in;
    cur.p0 = ref_pix(h, v, b, s0, 32, 32, 15, 80, 0, mc0c, mc0r);
    cur.p1 = ref_pix(h, v, b, {992'b0, s1}, 8, 4, 4, 10, 20, mc1c, mc1r);
    @(posedge clk);
    #1;
    chk("tick0", h, v, {7'b0, ft0}, {7'b0, tk});
    chk("tick1", h, v, {7'b0, ft1}, {7'b0, tk});
    ticks += int'(ft0);
    if (prev.valid) begin
      chk("pix0", prev.h, prev.v, pix0, prev.p0);
      chk("pix1", prev.h, prev.v, pix1, prev.p1);
      chk("hs0", prev.h, prev.v, {7'b0, hs0}, {7'b0, prev.hs});
      chk("vs0", prev.h, prev.v, {7'b0, vs0}, {7'b0, prev.vs});
      chk("hs1", prev.h, prev.v, {7'b0, hs1}, {7'b0, prev.hs});
      chk("vs1", prev.h, prev.v, {7'b0, vs1}, {7'b0, prev.vs});
      if (prev.dir)
        foreach (tbl[i])
          if (tbl[i].h == prev.h && tbl[i].v == prev.v)
            chk(tbl[i].d ? "vec1" : "vec0", prev.h, prev.v, tbl[i].d ? pix1 : pix0, tbl[i].e);
    end
    prev = cur;
  endtask

  task automatic line(int v, bit dir, bit rb);
    bit full = 0;
    foreach (fl[i]) if (fl[i] == v) full = 1;
    if (!dir && $urandom_range(127) == 0) full = 1;
    if (full)
      for (int h = 0; h < 564; h++)
        step(h, v, (h == 0 || h > 640 || v >= 480) || (rb && $urandom_range(15) == 0), dir);
    else
      step(0, v, 1'b1, dir);
  endtask

  task automatic frame(bit dir, bit rb, int last);
    ticks = 0;
    for (int v = 0; v <= last; v++) begin
      if (rb && v == 240) begin
        for (int i = 0; i < 32; i++) gp0[i*32 +: 32] = $urandom;
        gp1 = $urandom;
      end
      line(v, dir, rb);
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 32; i++) gp0[i*32 +: 32] = $urandom;
    gp1 = $urandom;
`ifdef GRID_CURSOR_EN
    cc0 = 5'($urandom); cr0 = 5'($urandom); cc1 = 3'($urandom); cr1 = 2'($urandom);
`endif
  endtask

  initial begin
    tbl = '{
      '{0, 80, 0, 8'hE0}, '{0, 81, 0, 8'hFF}, '{0, 95, 0, 8'hFF}, '{0, 95, 14, 8'hFF},
      '{0, 96, 0, 8'h00}, '{0, 81, 15, 8'h00}, '{0, 561, 0, 8'hE0}, '{0, 561, 479, 8'hE0},
      '{0, 546, 465, 8'hFF}, '{0, 560, 479, 8'hFF}, '{0, 545, 479, 8'h00}, '{0, 560, 464, 8'h00},
      '{0, 80, 480, 8'h00}, '{0, 562, 0, 8'h00},
      '{1, 10, 20, 8'hE0}, '{1, 43, 35, 8'hE0}, '{1, 10, 19, 8'h00}, '{1, 43, 36, 8'h00},
      '{1, 11, 20, 8'hFF}, '{1, 14, 23, 8'hFF}, '{1, 15, 20, 8'h00}, '{1, 11, 24, 8'h00},
      '{1, 39, 35, 8'hFF}, '{1, 42, 32, 8'hFF}, '{1, 38, 35, 8'h00}, '{1, 25, 28, 8'h00}};
    rst = 1; blank = 1; hcount = 0; vcount = 0; hs_in = 0; vs_in = 0;
    gp0 = '0; gp1 = '0; s0 = '0; s1 = '0; prev.valid = 0;
`ifdef GRID_CURSOR_EN
    cc0 = 5'd2; cr0 = 5'd3; cc1 = 3'd3; cr1 = 2'd1;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix0", 0, 0, pix0, 8'h00);
    chk("rst_pix1", 0, 0, pix1, 8'h00);
    chk("rst_sync0", 0, 0, {6'b0, hs0, vs0}, 8'h00);
    chk("rst_tick", 0, 0, {6'b0, ft0, ft1}, 8'h00);
    @(negedge clk);
    rst = 0;
    step(0, 524, 1'b1, 1'b0);
    gp0[0] = 1'b1;
    gp0[1023] = 1'b1;
    gp1 = 32'h8000_0001;
    frame(1'b1, 1'b0, 524);
    chk("ticks_per_frame", 0, 0, 8'(ticks), 8'd1);
    for (int f = 0; f < 2; f++) begin
      randomize_inputs();
      frame(1'b0, 1'b1, 524);
      chk("ticks_per_frame", f, 0, 8'(ticks), 8'd1);
    end
    gp0 = '1;
    gp1 = '1;
    frame(1'b0, 1'b0, 4);
    for (int h = 0; h <= 100; h++) begin
      force_sync = (h >= 97);
      step(h, 5, 1'b0, 1'b0);
    end
    force_sync = 0;
    chk("pre_rst_pix0", 99, 5, pix0, 8'hFF);
    #2;
    rst = 1;
    #1;
    chk("midrst_pix0", 100, 5, pix0, 8'h00);
    chk("midrst_pix1", 100, 5, pix1, 8'h00);
    chk("midrst_sync0", 100, 5, {6'b0, hs0, vs0}, 8'h00);
    chk("midrst_sync1", 100, 5, {6'b0, hs1, vs1}, 8'h00);
    chk("midrst_tick", 100, 5, {6'b0, ft0, ft1}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    pv = 0; s0 = '0; s1 = '0; prev.valid = 0;
    mc0c = 0; mc0r = 0; mc1c = 0; mc1r = 0;
    step(0, 524, 1'b1, 1'b0);
    randomize_inputs();
    frame(1'b0, 1'b1, 524);
    chk("ticks_per_frame", 9, 0, 8'(ticks), 8'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
